// File: rtl/tick_enable_multi.sv
// tick_enable_multi: multi-channel, runtime-programmable clock-enable generator.
// Each channel produces a one-cycle Enable tick every P cycles (periodic) or a
// single tick followed by a Done level (one-shot). Period registers are written
// through a shared Load port. A shared Sync strobe restarts every counting channel.
//
// Ports:
//   CLK        in   system clock, rising edge
//   Reset      in   asynchronous active-low reset
//   Run        in   [CHANNELS]  per-channel run request (level)
//   Oneshot    in   [CHANNELS]  mode captured on IDLE->COUNT (1 = one-shot)
//   Load       in   strobe: period[Load_Sel] <= Load_Value
//   Load_Sel   in   [SEL_W]     target channel (out-of-range writes are dropped)
//   Load_Value in   [WIDTH]     new period in CLK cycles (0 disables the channel)
//   Sync       in   strobe: every COUNT channel restarts its period
//   Enable     out  [CHANNELS]  registered one-cycle tick
//   Done       out  [CHANNELS]  registered, high while a one-shot channel is finished

module tick_enable_chan #(
  parameter int WIDTH       = 20,
  parameter int DEFAULT_DIV = 500000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  input  logic             oneshot,
  input  logic             sync,
  input  logic             load_wr,
  input  logic [WIDTH-1:0] load_value,
  output logic             enable,
  output logic             done
);

  typedef enum logic [1:0] {S_IDLE, S_COUNT, S_DONE} state_t;

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] per_q, per_d;
  logic             mode_q, mode_d;
  logic             en_q, en_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] reload;

  // Reloads always use the period held before this edge, so a Load landing on
  // the same edge as a reload only affects the following period.
  assign reload = per_q - ONE;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    en_d    = 1'b0;
    per_d   = load_wr ? load_value : per_q;
    unique case (state_q)
      S_IDLE: begin
        if (run && per_q != '0) begin
          state_d = S_COUNT;
          cnt_d   = reload;
          mode_d  = oneshot;
        end
      end
      S_COUNT: begin
        // Priority: Run drop > Sync > terminal count.
        if (!run) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else if (sync) begin
          if (per_q == '0) begin
            // Period was cleared; restarting would wrap, so park instead.
            state_d = S_IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = reload;
          end
        end else if (cnt_q == '0) begin
          en_d = 1'b1;
          if (mode_q)              state_d = S_DONE;
          else if (per_q == '0)    state_d = S_IDLE;
          else                     cnt_d   = reload;
        end else begin
          cnt_d = cnt_q - ONE;
        end
      end
      S_DONE: begin
        if (!run) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      per_q   <= WIDTH'(DEFAULT_DIV);
      mode_q  <= 1'b0;
      en_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      per_q   <= per_d;
      mode_q  <= mode_d;
      en_q    <= en_d;
      done_q  <= done_d;
    end
  end

  assign enable = en_q;
  assign done   = done_q;

endmodule

module tick_enable_multi #(
  parameter int CHANNELS    = 4,
  parameter int WIDTH       = 20,
  parameter int DEFAULT_DIV = 500000,
  parameter int SEL_W       = 2
) (
  input  logic                CLK,
  input  logic                Reset,
  input  logic [CHANNELS-1:0] Run,
  input  logic [CHANNELS-1:0] Oneshot,
  input  logic                Load,
  input  logic [SEL_W-1:0]    Load_Sel,
  input  logic [WIDTH-1:0]    Load_Value,
  input  logic                Sync,
  output logic [CHANNELS-1:0] Enable,
  output logic [CHANNELS-1:0] Done
);

  // Channel i only sees a write when Load_Sel matches i, so selects at or
  // beyond CHANNELS fall through without touching any period register.
  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    logic load_wr;
    assign load_wr = Load && (Load_Sel == SEL_W'(i));

    tick_enable_chan #(
      .WIDTH       (WIDTH),
      .DEFAULT_DIV (DEFAULT_DIV)
    ) u_chan (
      .clk        (CLK),
      .rst_n      (Reset),
      .run        (Run[i]),
      .oneshot    (Oneshot[i]),
      .sync       (Sync),
      .load_wr    (load_wr),
      .load_value (Load_Value),
      .enable     (Enable[i]),
      .done       (Done[i])
    );
  end

endmodule

// File: doc/tick_enable_multi.md
Name: tick_enable_multi

Overview:
- Multi-channel, runtime-programmable clock-enable generator.
- Parametrised successor of the fixed 200 Hz enable divider.
- Each channel emits a one-CLK-cycle Enable pulse exactly every P cycles, in periodic or one-shot mode.
- Per-channel period registers are loadable at run time; a global Sync re-aligns all channels.
- Feeds display-refresh, debounce and sampling logic that currently each carry their own hard-coded divider.

Parameters:
- CHANNELS, 4, number of independent enable channels (1..16).
- WIDTH, 20, width of period registers and down-counters.
- DEFAULT_DIV, 500000, period in CLK cycles loaded into every channel at reset; must be < 2^WIDTH.
- SEL_W, 2, width of Load_Sel; must satisfy 2^SEL_W >= CHANNELS.

Ports:
- CLK  in  1  system clock; all logic rising-edge.
- Reset  in  1  asynchronous, active-low reset.
- Run  in  CHANNELS  per-channel run request, level-sensitive.
- Oneshot  in  CHANNELS  per-channel mode, sampled on the IDLE->COUNT transition: 1 = single pulse, 0 = periodic.
- Load  in  1  single-cycle strobe writing Load_Value into period register Load_Sel.
- Load_Sel  in  SEL_W  target channel for Load.
- Load_Value  in  WIDTH  new period P in CLK cycles.
- Sync  in  1  single-cycle strobe restarting every counting channel.
- Enable  out  CHANNELS  registered one-cycle tick per channel.
- Done  out  CHANNELS  registered; high while a one-shot channel sits in DONE.

Behaviour:
- Reset low, asynchronous:
  - all states IDLE, counters 0, Enable 0, Done 0.
  - every period register = DEFAULT_DIV.
  - Load, Sync and Run are ignored while Reset is low.
- Per-channel FSM, states IDLE, COUNT, DONE:
  - IDLE: Enable 0, Done 0. If Run=1 and P!=0, go to COUNT, counter <= P-1, latch Oneshot into mode bit. If P=0 the channel stays IDLE (disabled).
  - COUNT, counter!=0: counter decrements by 1 per cycle, Enable <= 0.
  - COUNT, counter==0: Enable <= 1 for exactly one cycle. Periodic: counter <= P-1, stay in COUNT. One-shot: go to DONE.
  - COUNT, Run=0: go to IDLE next edge, counter <= 0, Enable <= 0. Run=0 has priority over terminal count, so no pulse is emitted that edge.
  - DONE: Enable 0, Done 1. Go to IDLE when Run=0. Run held high keeps the channel in DONE (no retrigger).
- Timing:
  - If Run is sampled high at edge k, the first Enable is high during the cycle after edge k+P.
  - Periodic pulses follow every P cycles exactly, with no off-by-one slip.
  - P=1 gives Enable constantly high while in COUNT (periodic mode).
- Load:
  - At the edge where Load=1, period[Load_Sel] <= Load_Value.
  - Load_Sel >= CHANNELS: write ignored.
  - A running counter is not disturbed; the new P takes effect at the next reload or IDLE->COUNT.
  - If a reload occurs on the same edge as the Load, the reload uses the old P.
  - Loading 0 into a COUNT channel: it finishes the current period, emits its pulse, then returns to IDLE instead of reloading.
- Sync:
  - Every channel in COUNT does counter <= P-1 and Enable <= 0 on that edge.
  - Sync has priority over terminal count (the pulse is suppressed) but not over Run=0.
  - IDLE and DONE channels are unaffected.
  - Load and Sync on the same edge: Sync reloads with the old P.
- Widths:
  - Counters and period registers are WIDTH bits, unsigned.
  - The counter never wraps; it is always reloaded at 0.
- Channels are fully independent except for shared Load and Sync.

Test Plan (bench: CHANNELS=2, WIDTH=8, DEFAULT_DIV=5, SEL_W=1):
- Reset low mid-count with ch0 running -> Enable=00, Done=00 immediately (asynchronous). After release and Run=01 at edge 0 -> ch0 pulses after edges 5, 10, 15 (period 5).
- Load Sel=1 Value=3, then Run=10 periodic -> ch1 pulses every 3 cycles. Load Value=7 mid-period -> the current period completes at 3, subsequent periods are 7.
- Oneshot=01, Run=01 held, P=4 -> a single pulse after edge 4, Done[0]=1 thereafter, no further pulses. Run=0 -> Done[0]=0 next edge. Run=1 again -> a new pulse 4 cycles later.
- Both channels periodic, P=5 and P=3, Sync asserted at an arbitrary cycle -> next pulses exactly 5 and 3 cycles after the Sync edge. Sync coincident with ch1 terminal count -> no ch1 pulse that cycle.
- P=1 periodic -> Enable[0] continuously 1. Load 0 -> one final pulse, then IDLE with Enable 0. Run dropped on a terminal-count edge -> no pulse.
- Load with Load_Sel out of range (CHANNELS=1 variant, Sel=1) -> no period register changes and ch0 timing is unchanged.
